// File: rtl/vending_credit_ctrl_if.sv
// Coin-acceptor and dispenser signal bundle for the vending credit controller.
// The coin mechanism (master) drives pulses; the controller (slave) returns sale/change status.
interface vending_credit_ctrl_if #(
    parameter int CREDIT_W = 8
);
    logic                nickel;
    logic                dime;
    logic                quarter;
    logic                dollar;
    logic                cancel;
    logic                dispense;
    logic                chg_quarter;
    logic                chg_dime;
    logic                chg_nickel;
    logic [CREDIT_W-1:0] credit;
    logic                busy;
    logic                coin_reject;

    modport master (
        output nickel, dime, quarter, dollar, cancel,
        input  dispense, chg_quarter, chg_dime, chg_nickel, credit, busy, coin_reject
    );

    modport slave (
        input  nickel, dime, quarter, dollar, cancel,
        output dispense, chg_quarter, chg_dime, chg_nickel, credit, busy, coin_reject
    );
endinterface

// File: rtl/vending_credit_ctrl.sv
// Vending credit controller: accumulates coins, dispenses at PRICE, pays change greedily.
// Outputs decode from registered state/credit only; coins presented while busy are rejected.
module vending_credit_ctrl #(
    parameter int PRICE    = 15,
    parameter int CREDIT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    vending_credit_ctrl_if.slave  bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCUM  = 2'd1;
    localparam logic [1:0] S_VEND   = 2'd2;
    localparam logic [1:0] S_CHANGE = 2'd3;

    localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] V_NICKEL = CREDIT_W'(1);
    localparam logic [CREDIT_W-1:0] V_DIME   = CREDIT_W'(2);
    localparam logic [CREDIT_W-1:0] V_QUART  = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] V_DOLLAR = CREDIT_W'(20);

    logic [1:0]          state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                reject_q, reject_d;

    logic                any_coin, multi_coin;
    logic [CREDIT_W-1:0] coin_val, sum, chg_val;

    always_comb begin
        any_coin   = bus.nickel | bus.dime | bus.quarter | bus.dollar;
        multi_coin = ($countones({bus.nickel, bus.dime, bus.quarter, bus.dollar}) > 1);

        coin_val = '0;
        if (bus.dollar)       coin_val = V_DOLLAR;
        else if (bus.quarter) coin_val = V_QUART;
        else if (bus.dime)    coin_val = V_DIME;
        else if (bus.nickel)  coin_val = V_NICKEL;
        sum = credit_q + coin_val;

        // Largest coin that still fits in the remaining credit.
        if (credit_q >= V_QUART)     chg_val = V_QUART;
        else if (credit_q >= V_DIME) chg_val = V_DIME;
        else                         chg_val = V_NICKEL;

        state_d  = state_q;
        credit_d = credit_q;
        reject_d = 1'b0;

        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (bus.cancel) begin
                    reject_d = any_coin;
                    if (state_q == S_ACCUM) state_d = S_CHANGE;
                end else if (any_coin) begin
                    reject_d = multi_coin;
                    credit_d = sum;
                    state_d  = (sum >= PRICE_C) ? S_VEND : S_ACCUM;
                end
            end
            S_VEND: begin
                reject_d = any_coin;
                credit_d = credit_q - PRICE_C;
                state_d  = (credit_q == PRICE_C) ? S_IDLE : S_CHANGE;
            end
            S_CHANGE: begin
                reject_d = any_coin;
                credit_d = credit_q - chg_val;
                state_d  = (credit_q == chg_val) ? S_IDLE : S_CHANGE;
            end
            default: begin
                state_d  = S_IDLE;
                credit_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            credit_q <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            reject_q <= reject_d;
        end
    end

    assign bus.dispense    = (state_q == S_VEND);
    assign bus.chg_quarter = (state_q == S_CHANGE) && (credit_q >= V_QUART);
    assign bus.chg_dime    = (state_q == S_CHANGE) && (credit_q < V_QUART) && (credit_q >= V_DIME);
    assign bus.chg_nickel  = (state_q == S_CHANGE) && (credit_q < V_DIME);
    assign bus.busy        = (state_q == S_VEND) || (state_q == S_CHANGE);
    assign bus.credit      = credit_q;
    assign bus.coin_reject = reject_q;
endmodule

// File: tb/tb_vending_credit_ctrl.sv
// Directed scenarios plus random coin traffic against a queue-based sale/refund model.
module tb_vending_credit_ctrl;
    localparam int PRICE = 15;
    localparam int CW    = 8;
    localparam int A_DISP = 0, A_Q = 1, A_D = 2, A_N = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vending_credit_ctrl_if #(.CREDIT_W(CW)) bus ();
    vending_credit_ctrl #(.PRICE(PRICE), .CREDIT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model: credit in nickels plus a queue of pending busy-cycle actions.
    int m_credit = 0;
    int m_q[$];
    bit m_rej = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic void push_change(input int amt);
        int a = amt;
        while (a > 0) begin
            if (a >= 5)      begin m_q.push_back(A_Q); a -= 5; end
            else if (a >= 2) begin m_q.push_back(A_D); a -= 2; end
            else             begin m_q.push_back(A_N); a -= 1; end
        end
    endfunction

    task automatic check_outputs();
        int act = (m_q.size() != 0) ? m_q[0] : -1;
        chk("credit",   int'(bus.credit),      m_credit);
        chk("dispense", int'(bus.dispense),    int'(act == A_DISP));
        chk("chg_q",    int'(bus.chg_quarter), int'(act == A_Q));
        chk("chg_d",    int'(bus.chg_dime),    int'(act == A_D));
        chk("chg_n",    int'(bus.chg_nickel),  int'(act == A_N));
        chk("busy",     int'(bus.busy),        int'(m_q.size() != 0));
        chk("reject",   int'(bus.coin_reject), int'(m_rej));
        chk("credit_max", int'(bus.credit <= CW'(PRICE + 19)), 1);
    endtask

    function automatic void model_step(input bit n, d, q, dl, c);
        bit any = n | d | q | dl;
        int a;
        if (m_q.size() != 0) begin
            a = m_q.pop_front();
            case (a)
                A_DISP:  m_credit -= PRICE;
                A_Q:     m_credit -= 5;
                A_D:     m_credit -= 2;
                default: m_credit -= 1;
            endcase
            m_rej = any;
        end else if (c) begin
            m_rej = any;
            push_change(m_credit);
        end else if (any) begin
            m_rej = (int'(n) + int'(d) + int'(q) + int'(dl)) > 1;
            m_credit += dl ? 20 : q ? 5 : d ? 2 : 1;
            if (m_credit >= PRICE) begin
                m_q.push_back(A_DISP);
                push_change(m_credit - PRICE);
            end
        end else begin
            m_rej = 1'b0;
        end
    endfunction

    // Called at a negedge: drive one cycle of inputs, then check the next cycle's outputs.
    task automatic cycle(input bit n, d, q, dl, c);
        bus.nickel = n; bus.dime = d; bus.quarter = q; bus.dollar = dl; bus.cancel = c;
        model_step(n, d, q, dl, c);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0);
    endtask

    task automatic async_reset();
        bus.nickel = 0; bus.dime = 0; bus.quarter = 0; bus.dollar = 0; bus.cancel = 0;
        #2 reset = 1'b1;
        #1;
        chk("rst_credit", int'(bus.credit), 0);
        chk("rst_busy",   int'(bus.busy), 0);
        chk("rst_chg",    int'(bus.chg_quarter | bus.chg_dime | bus.chg_nickel), 0);
        chk("rst_disp",   int'(bus.dispense), 0);
        chk("rst_rej",    int'(bus.coin_reject), 0);
        m_credit = 0;
        m_q.delete();
        m_rej = 1'b0;
        @(negedge clk);
        check_outputs();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.nickel = 0; bus.dime = 0; bus.quarter = 0; bus.dollar = 0; bus.cancel = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("init_credit", int'(bus.credit), 0);
        chk("init_busy",   int'(bus.busy), 0);
        check_outputs();

        // Exact price with three quarters
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        chk("q3_disp",   int'(bus.dispense), 1);
        chk("q3_credit", int'(bus.credit), 15);
        idle();
        chk("q3_done", int'(bus.credit), 0);

        // Dollar: one quarter of change
        cycle(0, 0, 0, 1, 0);
        chk("dl_credit", int'(bus.credit), 20);
        idle();
        chk("dl_chg_q", int'(bus.chg_quarter), 1);
        idle();
        chk("dl_done", int'(bus.busy), 0);

        // Dime, nickel, cancel: refund dime then nickel
        cycle(0, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        chk("cx_chg_d", int'(bus.chg_dime), 1);
        idle();
        chk("cx_chg_n", int'(bus.chg_nickel), 1);
        idle();

        // Simultaneous coins, then quarter with cancel
        cycle(1, 1, 1, 0, 0);
        chk("multi_credit", int'(bus.credit), 5);
        chk("multi_rej",    int'(bus.coin_reject), 1);
        cycle(0, 0, 1, 0, 1);
        chk("qc_rej",   int'(bus.coin_reject), 1);
        chk("qc_chg_q", int'(bus.chg_quarter), 1);
        idle();

        // Coin during change
        cycle(0, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 1, 0, 0);
        chk("busy_rej",   int'(bus.coin_reject), 1);
        chk("busy_chg_n", int'(bus.chg_nickel), 1);
        idle();

        // Reset in the middle of a refund
        cycle(0, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        chk("mid_credit", int'(bus.credit), 3);
        async_reset();
        cycle(0, 0, 1, 0, 0);
        chk("post_rst_credit", int'(bus.credit), 5);
        cycle(0, 0, 0, 0, 1);
        repeat (2) idle();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
            end else begin
                cycle($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                      $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0,
                      $urandom_range(0, 11) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/vending_credit_ctrl.md
VENDING_CREDIT_CTRL -- requirements
Module: vending_credit_ctrl

Interface
REQ-001 Parameter PRICE, default 15, item price in nickel units (5 cents each); SHALL be 1..255.
REQ-002 Parameter CREDIT_W, default 8, credit register width; SHALL satisfy 2^CREDIT_W > PRICE+19.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge only.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 nickel  input  1  5-cent coin, one-cycle pulse.
REQ-006 dime  input  1  10-cent coin, one-cycle pulse.
REQ-007 quarter  input  1  25-cent coin, one-cycle pulse.
REQ-008 dollar  input  1  100-cent coin, one-cycle pulse.
REQ-009 cancel  input  1  refund request, one-cycle pulse.
REQ-010 dispense  output  1  item release, high for exactly one cycle per sale.
REQ-011 chg_quarter, chg_dime, chg_nickel  output  1 each  change-coin ejects, each high means one coin this cycle.
REQ-012 credit  output  CREDIT_W  current credit in nickel units.
REQ-013 busy  output  1  high in VEND or CHANGE; coins are not accepted.
REQ-014 coin_reject  output  1  one-cycle pulse, a coin was presented but not accepted.

Function
REQ-015 The controller SHALL have states IDLE (credit 0), ACCUM (0 < credit < PRICE), VEND and CHANGE.
REQ-016 Coin values SHALL be nickel=1, dime=2, quarter=5, dollar=20 units.
REQ-017 In IDLE/ACCUM at most one coin SHALL be accepted per cycle. Priority is dollar > quarter > dime > nickel. Lower-priority simultaneous coins are rejected.
REQ-018 An accepted coin in cycle N SHALL make credit = old credit + value from cycle N+1.
REQ-019 If the new credit >= PRICE, the next state SHALL be VEND; otherwise ACCUM.
REQ-020 VEND SHALL last exactly one cycle with dispense=1. On exit, credit becomes credit-PRICE. The next state is CHANGE if the remainder > 0, else IDLE.
REQ-021 Each CHANGE cycle SHALL assert exactly one change output, decided greedily from the registered credit:
- chg_quarter if credit >= 5
- else chg_dime if credit >= 2
- else chg_nickel
REQ-022 Each CHANGE cycle SHALL decrement credit by 5, 2 or 1 to match the ejected coin. When the credit reaches 0 the state SHALL go to IDLE.
REQ-023 cancel in ACCUM SHALL enter CHANGE with credit unchanged and no dispense, so the full credit is refunded.
REQ-024 cancel in IDLE, VEND or CHANGE SHALL be ignored.
REQ-025 cancel together with a coin in the same cycle: cancel wins and every coin present SHALL be rejected.
REQ-026 Any coin high in VEND or CHANGE SHALL be rejected; credit and state are unaffected.
REQ-027 coin_reject SHALL be high in cycle N+1 if any coin input was high in cycle N and not accepted.
REQ-028 dispense, chg_*, busy and credit SHALL be decoded from registered state and credit only; there SHALL be no combinational path from any input.
REQ-029 At most one of dispense and chg_* SHALL be high in any cycle.
REQ-030 Credit SHALL never exceed PRICE+19 and never underflow.

Reset
REQ-031 reset asserted SHALL immediately force IDLE, credit=0 and all outputs 0, including in mid-VEND or mid-CHANGE. Remaining change is forfeited.
REQ-032 After reset deasserts, the first rising edge SHALL process inputs normally.

Verification (PRICE=15)
REQ-033 3 quarters on separate cycles -> credit 5, 10, 15; one VEND cycle with dispense=1; then IDLE, credit 0, no change pulses.
REQ-034 dollar from IDLE -> credit 20, VEND (dispense), credit 5, one CHANGE cycle with chg_quarter; then IDLE, credit 0.
REQ-035 dime, then nickel, then cancel -> credit 2, 3; CHANGE emits chg_dime then chg_nickel; credit 0, IDLE, dispense never high.
REQ-036 quarter+dime+nickel in the same cycle from IDLE -> credit 5, coin_reject pulse next cycle; quarter+cancel in ACCUM (credit 5) -> coin rejected and refund of one quarter.
REQ-037 Coin during CHANGE -> coin_reject pulse, change sequence unaltered.
REQ-038 reset mid-CHANGE (remaining credit 3) -> credit 0, IDLE and all outputs 0 immediately; then a quarter is accepted normally.
